// File: rtl/anubis_vector_bist.sv
// Vector-replay BIST sequencer for the anubis core: stores key/plain/expected vectors,
// replays them through the core and counts passes/failures. Optional macro: ANUBIS_BIST_DECRYPT_EN.
module anubis_vector_bist #(
  parameter int KEY_W           = 128,
  parameter int BLOCK_W         = 128,
  parameter int ADDR_W          = 4,
  parameter int CORE_RST_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vec_we,
  input  logic [ADDR_W-1:0]  vec_addr,
  input  logic [KEY_W-1:0]   vec_key,
  input  logic [BLOCK_W-1:0] vec_plain,
  input  logic [BLOCK_W-1:0] vec_expected,
  input  logic [ADDR_W:0]    num_vec,
  input  logic               start,
  output logic               core_reset,
  output logic               core_encrypt,
  output logic [KEY_W-1:0]   core_key,
  output logic [BLOCK_W-1:0] core_plain,
  input  logic [BLOCK_W-1:0] core_cipher,
  input  logic               core_end_flag,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    pass_cnt,
  output logic [ADDR_W:0]    fail_cnt,
  output logic [ADDR_W-1:0]  first_fail_idx,
  output logic               timeout_seen
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int ENT_W = KEY_W + 2 * BLOCK_W;
  localparam int RC_W  = $clog2(CORE_RST_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(CORE_RST_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CRST, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W:0]    num_q, num_d;
  logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               end_d_q;
  logic [BLOCK_W-1:0] cipher_q, cipher_d;
  logic               timed_out_q, timed_out_d;
  logic [ADDR_W:0]    pass_cnt_q, pass_cnt_d;
  logic [ADDR_W:0]    fail_cnt_q, fail_cnt_d;
  logic [ADDR_W-1:0]  first_fail_idx_q, first_fail_idx_d;
  logic               timeout_seen_q, timeout_seen_d;
`ifdef ANUBIS_BIST_DECRYPT_EN
  logic               leg_q, leg_d;
  logic               enc_fail_q, enc_fail_d;
`endif

  // Vector RAM: one word per vector, registered read so it maps onto block RAM.
  logic [ENT_W-1:0]   ram [DEPTH];
  logic [ENT_W-1:0]   ent_q;
  logic               ram_we, ram_re;
  logic [KEY_W-1:0]   ent_key;
  logic [BLOCK_W-1:0] ent_plain, ent_exp, ref_val;
  logic               edge_hit, leg_fail, vec_end, vec_fail;

  assign ram_we    = vec_we & ~busy;
  assign ram_re    = (state_q == S_LOAD);
  assign ent_key   = ent_q[ENT_W-1 -: KEY_W];
  assign ent_plain = ent_q[2*BLOCK_W-1 -: BLOCK_W];
  assign ent_exp   = ent_q[BLOCK_W-1:0];

  always_ff @(posedge clk) begin
    if (ram_we) ram[vec_addr] <= {vec_key, vec_plain, vec_expected};
  end

  always_ff @(posedge clk) begin
    if (reset)       ent_q <= '0;
    else if (ram_re) ent_q <= ram[idx_q];
  end

`ifdef ANUBIS_BIST_DECRYPT_EN
  assign ref_val      = leg_q ? ent_plain : ent_exp;
  assign core_plain   = leg_q ? ent_exp : ent_plain;
  assign core_encrypt = ~leg_q;
`else
  assign ref_val      = ent_exp;
  assign core_plain   = ent_plain;
  assign core_encrypt = 1'b1;
`endif
  assign core_key       = ent_key;
  assign core_reset     = (state_q != S_WAIT) && (state_q != S_CHECK);
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = first_fail_idx_q;
  assign timeout_seen   = timeout_seen_q;

  // A flag already high when WAIT is entered has end_d_q set, so it never looks like an edge.
  assign edge_hit = core_end_flag & ~end_d_q;
  assign leg_fail = timed_out_q | (cipher_q != ref_val);

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    num_d            = num_q;
    rst_cnt_d        = rst_cnt_q;
    to_cnt_d         = to_cnt_q;
    cipher_d         = cipher_q;
    timed_out_d      = timed_out_q;
    pass_cnt_d       = pass_cnt_q;
    fail_cnt_d       = fail_cnt_q;
    first_fail_idx_d = first_fail_idx_q;
    timeout_seen_d   = timeout_seen_q;
`ifdef ANUBIS_BIST_DECRYPT_EN
    leg_d            = leg_q;
    enc_fail_d       = enc_fail_q;
`endif
    vec_end          = 1'b0;
    vec_fail         = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d            = (num_vec > DEPTH_C) ? DEPTH_C : num_vec;
          idx_d            = '0;
          pass_cnt_d       = '0;
          fail_cnt_d       = '0;
          first_fail_idx_d = '0;
          timeout_seen_d   = 1'b0;
`ifdef ANUBIS_BIST_DECRYPT_EN
          leg_d            = 1'b0;
`endif
          state_d          = (num_vec == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        rst_cnt_d = '0;
        state_d   = S_CRST;
      end
      S_CRST: begin
        if (rst_cnt_q == RC_LAST) begin
          to_cnt_d = '0;
          state_d  = S_WAIT;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // An edge on the final timeout cycle still counts as a normal completion.
        if (edge_hit) begin
          cipher_d    = core_cipher;
          timed_out_d = 1'b0;
          state_d     = S_CHECK;
        end else if (to_cnt_q == TO_LAST) begin
          timed_out_d    = 1'b1;
          timeout_seen_d = 1'b1;
          state_d        = S_CHECK;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
`ifdef ANUBIS_BIST_DECRYPT_EN
        if (!leg_q) begin
          leg_d      = 1'b1;
          enc_fail_d = leg_fail;
          rst_cnt_d  = '0;
          state_d    = S_CRST;
        end else begin
          leg_d    = 1'b0;
          vec_end  = 1'b1;
          vec_fail = enc_fail_q | leg_fail;
        end
`else
        vec_end  = 1'b1;
        vec_fail = leg_fail;
`endif
        if (vec_end) begin
          if (vec_fail) begin
            if (fail_cnt_q == '0) first_fail_idx_d = idx_q;
            fail_cnt_d = fail_cnt_q + 1'b1;
          end else begin
            pass_cnt_d = pass_cnt_q + 1'b1;
          end
          if (({1'b0, idx_q} + 1'b1) < num_q) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      num_q            <= '0;
      rst_cnt_q        <= '0;
      to_cnt_q         <= '0;
      end_d_q          <= 1'b0;
      cipher_q         <= '0;
      timed_out_q      <= 1'b0;
      pass_cnt_q       <= '0;
      fail_cnt_q       <= '0;
      first_fail_idx_q <= '0;
      timeout_seen_q   <= 1'b0;
`ifdef ANUBIS_BIST_DECRYPT_EN
      leg_q            <= 1'b0;
      enc_fail_q       <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      num_q            <= num_d;
      rst_cnt_q        <= rst_cnt_d;
      to_cnt_q         <= to_cnt_d;
      end_d_q          <= core_end_flag;
      cipher_q         <= cipher_d;
      timed_out_q      <= timed_out_d;
      pass_cnt_q       <= pass_cnt_d;
      fail_cnt_q       <= fail_cnt_d;
      first_fail_idx_q <= first_fail_idx_d;
      timeout_seen_q   <= timeout_seen_d;
`ifdef ANUBIS_BIST_DECRYPT_EN
      leg_q            <= leg_d;
      enc_fail_q       <= enc_fail_d;
`endif
    end
  end
endmodule
